// File: rtl/dpb_ppfifo_sched_pkg.sv
// Shared types for the dual-port-BRAM / ping-pong-FIFO transfer scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dpb_ppfifo_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_END   = 3'd3,
        ST_CANCEL     = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        STS_OK       = 2'd0,
        STS_START_TO = 2'd1,
        STS_END_TO   = 2'd2
    } status_t;

    // Bit positions inside o_grant.
    localparam int GNT_WR = 0;
    localparam int GNT_RD = 1;

    // Round-robin pick: read wins when it is the only requester, or when
    // both are pending and read holds the priority token.
    function automatic logic pick_rd(input logic wr_req, input logic rd_req,
                                     input logic prio_rd);
        return rd_req && (!wr_req || prio_rd);
    endfunction

endpackage

// File: rtl/dpb_ppfifo_xfer_sched_sync_bit.sv
// Single-bit multi-flop synchronizer for a level from a foreign clock domain.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; free-running flop chain.
// Ports: clk/rst (sync, active-high), d async level in, q synchronized level out.
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Fewer than two stages is not a synchronizer; clamp silently.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {N{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/dpb_ppfifo_xfer_sched.sv
// Control-side scheduler for the BRAM <-> PPFIFO adapter: round-robin grant,
// strobe/enable issue, completion tracking via the adapter idle flag, timeout cancel.
// Latency: ack 1 cycle after request is seen; strobe/enable 1 cycle after ack.
// Backpressure: requests are levels held until ack; a new grant waits for IDLE.
// Ports: i_wr_req/o_wr_ack, i_rd_req/o_rd_ack requester handshakes; i_timeout
// per-phase limit (0 = off); o_busy/o_grant/o_done/o_status transfer status;
// o_mem_2_ppfifo_stb, o_ppfifo_2_mem_en, o_cancel_write_stb, i_adapter_idle to adapter.
module dpb_ppfifo_xfer_sched
    import dpb_ppfifo_sched_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = 24,
    parameter int SYNC_STAGES   = 2,
    parameter int CANCEL_HOLD   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_req,
    output logic                     o_wr_ack,
    input  logic                     i_rd_req,
    output logic                     o_rd_ack,
    input  logic [TIMEOUT_WIDTH-1:0] i_timeout,
    output logic                     o_busy,
    output logic [1:0]               o_grant,
    output logic                     o_done,
    output logic [1:0]               o_status,
    output logic                     o_mem_2_ppfifo_stb,
    output logic                     o_ppfifo_2_mem_en,
    output logic                     o_cancel_write_stb,
    input  logic                     i_adapter_idle
);

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE  = TIMEOUT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_HOLD = TIMEOUT_WIDTH'(CANCEL_HOLD);

    logic idle_s;

    // The adapter shares rst and is idle after it, so the chain resets to 1.
    sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_idle_sync (
        .clk (clk),
        .rst (rst),
        .d   (i_adapter_idle),
        .q   (idle_s)
    );

    state_t                   state_q,   state_d;
    status_t                  sts_q,     sts_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q,     cnt_d;
    logic                     prio_rd_q, prio_rd_d;
    logic                     wr_ack_q,  wr_ack_d;
    logic                     rd_ack_q,  rd_ack_d;
    logic [1:0]               grant_q,   grant_d;
    logic                     busy_q,    busy_d;
    logic                     done_q,    done_d;
    logic [1:0]               status_q,  status_d;
    logic                     stb_q,     stb_d;
    logic                     en_q,      en_d;
    logic                     cancel_q,  cancel_d;

    logic                     rd_sel;
    logic                     timeout_hit;
    logic [TIMEOUT_WIDTH-1:0] cnt_dec;

    // A counter loaded with 0 never decrements and so never reads 1:
    // that is what makes i_timeout == 0 mean "no timeout".
    assign timeout_hit = (cnt_q == CNT_ONE);
    assign cnt_dec     = (cnt_q != '0) ? (cnt_q - CNT_ONE) : cnt_q;

    always_comb begin
        state_d   = state_q;
        sts_d     = sts_q;
        cnt_d     = cnt_q;
        prio_rd_d = prio_rd_q;
        grant_d   = grant_q;
        en_d      = en_q;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;
        done_d    = 1'b0;
        status_d  = STS_OK;
        stb_d     = 1'b0;
        cancel_d  = 1'b0;
        rd_sel    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_wr_req || i_rd_req) begin
                    rd_sel   = pick_rd(i_wr_req, i_rd_req, prio_rd_q);
                    wr_ack_d = !rd_sel;
                    rd_ack_d = rd_sel;
                    grant_d  = rd_sel ? 2'b10 : 2'b01;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (grant_q[GNT_WR]) begin
                    stb_d = 1'b1;
                end else begin
                    en_d  = 1'b1;
                end
                cnt_d   = i_timeout;
                state_d = ST_WAIT_START;
            end

            ST_WAIT_START: begin
                // Adapter leaving idle is checked first so it beats a
                // timeout landing on the same cycle.
                if (!idle_s) begin
                    cnt_d   = i_timeout;
                    state_d = ST_WAIT_END;
                end else if (timeout_hit) begin
                    cancel_d = 1'b1;
                    en_d     = 1'b0;
                    sts_d    = STS_START_TO;
                    cnt_d    = CNT_HOLD;
                    state_d  = ST_CANCEL;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            ST_WAIT_END: begin
                if (idle_s) begin
                    en_d    = 1'b0;
                    sts_d   = STS_OK;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    cancel_d = 1'b1;
                    en_d     = 1'b0;
                    sts_d    = STS_END_TO;
                    cnt_d    = CNT_HOLD;
                    state_d  = ST_CANCEL;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            ST_CANCEL: begin
                // Counter now counts the post-cancel hold time.
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            ST_DONE: begin
                done_d    = 1'b1;
                status_d  = sts_q;
                grant_d   = 2'b00;
                // Whoever just finished loses priority to the other side.
                prio_rd_d = grant_q[GNT_WR];
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end

            default: begin
                grant_d = 2'b00;
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sts_q     <= STS_OK;
            cnt_q     <= '0;
            prio_rd_q <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            grant_q   <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            status_q  <= 2'b00;
            stb_q     <= 1'b0;
            en_q      <= 1'b0;
            cancel_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sts_q     <= sts_d;
            cnt_q     <= cnt_d;
            prio_rd_q <= prio_rd_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            status_q  <= status_d;
            stb_q     <= stb_d;
            en_q      <= en_d;
            cancel_q  <= cancel_d;
        end
    end

    assign o_wr_ack           = wr_ack_q;
    assign o_rd_ack           = rd_ack_q;
    assign o_grant            = grant_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_status           = status_q;
    assign o_mem_2_ppfifo_stb = stb_q;
    assign o_ppfifo_2_mem_en  = en_q;
    assign o_cancel_write_stb = cancel_q;

endmodule

// File: tb/tb_dpb_ppfifo_xfer_sched.sv
// Directed self-checking bench for dpb_ppfifo_xfer_sched with a small adapter idle model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dpb_ppfifo_xfer_sched;

    logic        clk;
    logic        rst;
    logic        i_wr_req;
    logic        i_rd_req;
    logic [23:0] i_timeout;
    logic        i_adapter_idle;
    logic        o_wr_ack;
    logic        o_rd_ack;
    logic        o_busy;
    logic [1:0]  o_grant;
    logic        o_done;
    logic [1:0]  o_status;
    logic        o_mem_2_ppfifo_stb;
    logic        o_ppfifo_2_mem_en;
    logic        o_cancel_write_stb;

    int n_err = 0;
    int n_chk = 0;
    int mdl_mode = 0; // 0 normal, 1 idle never drops, 2 idle never returns

    dpb_ppfifo_xfer_sched #(
        .TIMEOUT_WIDTH (24),
        .SYNC_STAGES   (2),
        .CANCEL_HOLD   (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_wr_req           (i_wr_req),
        .o_wr_ack           (o_wr_ack),
        .i_rd_req           (i_rd_req),
        .o_rd_ack           (o_rd_ack),
        .i_timeout          (i_timeout),
        .o_busy             (o_busy),
        .o_grant            (o_grant),
        .o_done             (o_done),
        .o_status           (o_status),
        .o_mem_2_ppfifo_stb (o_mem_2_ppfifo_stb),
        .o_ppfifo_2_mem_en  (o_ppfifo_2_mem_en),
        .o_cancel_write_stb (o_cancel_write_stb),
        .i_adapter_idle     (i_adapter_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adapter model: leaves idle 3 cycles after a write strobe or read-enable
    // rise, returns 20 cycles later; cancel or reset forces it back to idle.
    initial begin : adapter_model
        int   phase;
        int   cnt;
        logic en_prev;
        i_adapter_idle = 1'b1;
        phase   = 0;
        cnt     = 0;
        en_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                i_adapter_idle = 1'b1;
                phase = 0;
            end else if (o_cancel_write_stb) begin
                i_adapter_idle = 1'b1;
                phase = 0;
            end else begin
                case (phase)
                    0: if ((o_mem_2_ppfifo_stb || (o_ppfifo_2_mem_en && !en_prev))
                           && mdl_mode != 1) begin
                        phase = 1;
                        cnt   = 3;
                    end
                    1: begin
                        cnt = cnt - 1;
                        if (cnt == 0) begin
                            i_adapter_idle = 1'b0;
                            phase = 2;
                            cnt   = 20;
                        end
                    end
                    2: if (mdl_mode != 2) begin
                        cnt = cnt - 1;
                        if (cnt == 0) begin
                            i_adapter_idle = 1'b1;
                            phase = 0;
                        end
                    end
                    default: phase = 0;
                endcase
            end
            en_prev = o_ppfifo_2_mem_en;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_wr_ack || o_rd_ack) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle_fall(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!i_adapter_idle) break;
        end
    endtask

    initial begin : stim
        logic got;
        int   stb_cnt, gbad, dly, dones, busy_bad, canc_cnt, en_bad;
        logic c_after;
        logic [1:0] exp_order [4];
        exp_order[0] = 2'b01; exp_order[1] = 2'b10;
        exp_order[2] = 2'b01; exp_order[3] = 2'b10;

        rst = 1'b1; i_wr_req = 1'b0; i_rd_req = 1'b0; i_timeout = 24'd200;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {o_wr_ack, o_rd_ack, o_busy, o_grant, o_done, o_status,
                              o_mem_2_ppfifo_stb, o_ppfifo_2_mem_en, o_cancel_write_stb}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // ---- write only ----
        i_wr_req = 1'b1;
        @(negedge clk);
        chk("wr_ack", o_wr_ack, 1);
        chk("wr_grant", o_grant, 2'b01);
        chk("wr_busy", o_busy, 1);
        i_wr_req = 1'b0;
        stb_cnt = 0; gbad = 0; got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_done) begin got = 1'b1; break; end
            stb_cnt += int'(o_mem_2_ppfifo_stb);
            if (o_grant != 2'b01) gbad++;
        end
        chk("wr_done_seen", got, 1);
        chk("wr_status", o_status, 2'b00);
        chk("wr_stb_cycles", stb_cnt, 1);
        chk("wr_grant_held", gbad, 0);
        chk("wr_grant_clear", o_grant, 2'b00);
        @(negedge clk);
        chk("wr_done_pulse", o_done, 0);

        // ---- read only ----
        i_rd_req = 1'b1;
        @(negedge clk);
        chk("rd_ack", o_rd_ack, 1);
        chk("rd_grant", o_grant, 2'b10);
        i_rd_req = 1'b0;
        @(negedge clk);
        chk("rd_en_on", o_ppfifo_2_mem_en, 1);
        wait_idle_fall(50);
        en_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i_adapter_idle) break;
            if (!o_ppfifo_2_mem_en || o_grant != 2'b10) en_bad++;
        end
        chk("rd_en_held", en_bad, 0);
        repeat (2) @(negedge clk);
        chk("rd_en_before_drop", o_ppfifo_2_mem_en, 1);
        @(negedge clk);
        chk("rd_en_drop", o_ppfifo_2_mem_en, 0);
        @(negedge clk);
        chk("rd_done", o_done, 1);
        chk("rd_status", o_status, 2'b00);

        // ---- both requesters, twice ----
        dones = 0;
        for (int p = 0; p < 2; p++) begin
            i_wr_req = 1'b1; i_rd_req = 1'b1;
            for (int t = 0; t < 2; t++) begin
                wait_ack(100, got);
                chk($sformatf("both_order_%0d", p * 2 + t), {o_rd_ack, o_wr_ack},
                    exp_order[p * 2 + t]);
                if (o_wr_ack) i_wr_req = 1'b0;
                if (o_rd_ack) i_rd_req = 1'b0;
                wait_done(200, got);
                if (got) dones++;
            end
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            dones += int'(o_done);
        end
        chk("both_done_count", dones, 4);

        // ---- start timeout ----
        mdl_mode = 1; i_timeout = 24'd10;
        i_wr_req = 1'b1;
        wait_ack(20, got);
        i_wr_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_mem_2_ppfifo_stb) break;
        end
        dly = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (o_cancel_write_stb) begin dly = i; break; end
        end
        chk("sto_cancel_delay", dly, 10);
        dly = 0; c_after = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) c_after = o_cancel_write_stb;
            if (o_done) begin dly = i; break; end
        end
        chk("sto_cancel_width", c_after, 0);
        chk("sto_done_delay", dly, 9);
        chk("sto_status", o_status, 2'b01);
        mdl_mode = 0;

        // ---- end timeout ----
        mdl_mode = 2; i_timeout = 24'd50;
        i_wr_req = 1'b1;
        wait_ack(20, got);
        i_wr_req = 1'b0;
        wait_idle_fall(50);
        dly = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (o_cancel_write_stb) begin dly = i; break; end
        end
        chk("eto_cancel_delay", dly, 53);
        wait_done(40, got);
        chk("eto_done_seen", got, 1);
        chk("eto_status", o_status, 2'b10);
        mdl_mode = 0;

        // ---- zero timeout, idle stuck low ----
        mdl_mode = 2; i_timeout = 24'd0;
        i_wr_req = 1'b1;
        wait_ack(20, got);
        i_wr_req = 1'b0;
        canc_cnt = 0; busy_bad = 0; dones = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            canc_cnt += int'(o_cancel_write_stb);
            busy_bad += int'(!o_busy);
            dones    += int'(o_done);
        end
        chk("zto_no_cancel", canc_cnt, 0);
        chk("zto_busy_held", busy_bad, 0);
        chk("zto_no_done", dones, 0);
        mdl_mode = 0;
        wait_done(100, got);
        chk("zto_done_seen", got, 1);
        chk("zto_status", o_status, 2'b00);

        // ---- reset during read WAIT_END ----
        i_rd_req = 1'b1;
        wait_ack(20, got);
        chk("rst_rd_ack", o_rd_ack, 1);
        i_rd_req = 1'b0;
        wait_idle_fall(50);
        repeat (5) @(negedge clk);
        chk("rst_pre_en", o_ppfifo_2_mem_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_en", o_ppfifo_2_mem_en, 0);
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dones += int'(o_done);
        end
        chk("rst_no_done", dones, 0);
        i_wr_req = 1'b1; i_rd_req = 1'b1;
        wait_ack(20, got);
        chk("rst_wr_first", {o_rd_ack, o_wr_ack}, 2'b01);
        i_wr_req = 1'b0; i_rd_req = 1'b0;
        wait_done(200, got);
        chk("rst_wr_done", got, 1);
        chk("rst_wr_status", o_status, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
